// File: rtl/adsr_vca.sv
// Five-state ADSR envelope generator driving a VCA on a signed audio sample.
// The output is registered; env_level and active decode the state and accumulator directly.
module adsr_vca #(
    parameter int unsigned DATA_BITS = 12,
    parameter int unsigned ACC_BITS  = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 gate_i,
    input  logic [3:0]           attack_i,
    input  logic [3:0]           decay_i,
    input  logic [3:0]           sustain_i,
    input  logic [3:0]           release_i,
    input  logic [DATA_BITS-1:0] in_i,
    output logic [DATA_BITS-1:0] out_o,
    output logic [7:0]           env_level_o,
    output logic                 active_o
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAttack  = 3'd1;
    localparam logic [2:0] StDecay   = 3'd2;
    localparam logic [2:0] StSustain = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    localparam logic [ACC_BITS-1:0] AccFull = '1;

    function automatic logic [ACC_BITS-1:0] rate_inc(input logic [3:0] r);
        logic [ACC_BITS-1:0] one;
        one = {{(ACC_BITS-1){1'b0}}, 1'b1};
        return one << (ACC_BITS - 9 - 32'(r));
    endfunction

    logic [2:0]           state_q, state_d;
    logic [ACC_BITS-1:0]  acc_q, acc_d;
    logic                 gate_q;
    logic                 armed_q;
    logic [DATA_BITS-1:0] out_q, out_d;

    logic [ACC_BITS-1:0]  inc_attack, inc_decay, inc_release;
    logic [ACC_BITS-1:0]  tgt;
    logic [ACC_BITS:0]    att_sum, dec_diff;
    logic                 rise, fall;

    assign inc_attack  = rate_inc(attack_i);
    assign inc_decay   = rate_inc(decay_i);
    assign inc_release = rate_inc(release_i);
    assign tgt         = {sustain_i, sustain_i, {(ACC_BITS-8){1'b0}}};

    // One extra bit keeps the attack overflow and decay underflow compares from wrapping.
    assign att_sum  = {1'b0, acc_q} + {1'b0, inc_attack};
    assign dec_diff = {1'b0, acc_q} - {1'b0, inc_decay};

    // armed_q masks the first edge out of reset so a gate already held high does not trigger.
    assign rise = gate_i & ~gate_q & armed_q;
    assign fall = ~gate_i & ((state_q == StAttack) | (state_q == StDecay) |
                             (state_q == StSustain));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (rise) begin
            state_d = StAttack;
        end else if (fall) begin
            state_d = StRelease;
        end else begin
            case (state_q)
                StIdle: begin
                    acc_d = '0;
                end
                StAttack: begin
                    if (att_sum >= {1'b0, AccFull}) begin
                        acc_d   = AccFull;
                        state_d = StDecay;
                    end else begin
                        acc_d = att_sum[ACC_BITS-1:0];
                    end
                end
                StDecay: begin
                    if ($signed(dec_diff) <= $signed({1'b0, tgt})) begin
                        acc_d   = tgt;
                        state_d = StSustain;
                    end else begin
                        acc_d = dec_diff[ACC_BITS-1:0];
                    end
                end
                StSustain: begin
                    acc_d = tgt;
                end
                StRelease: begin
                    if (acc_q <= inc_release) begin
                        acc_d   = '0;
                        state_d = StIdle;
                    end else begin
                        acc_d = acc_q - inc_release;
                    end
                end
                default: begin
                    acc_d   = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    logic [7:0]                  env_level;
    logic [8:0]                  mul_m;
    logic [DATA_BITS+9:0]        in_ext;
    logic [DATA_BITS+9:0]        m_ext;
    logic signed [DATA_BITS+9:0] prod;
    logic                        unused_prod;

    assign env_level = acc_q[ACC_BITS-1 -: 8];
    // Full level maps to 256 so the VCA reaches exact unity gain.
    assign mul_m     = (env_level == 8'hFF) ? 9'd256 : {1'b0, env_level};
    assign in_ext    = {{10{in_i[DATA_BITS-1]}}, in_i};
    assign m_ext     = {{(DATA_BITS+1){1'b0}}, mul_m};
    assign prod      = $signed(in_ext) * $signed(m_ext);
    assign out_d     = prod[DATA_BITS+7:8];
    assign unused_prod = ^{prod[DATA_BITS+9:DATA_BITS+8], prod[7:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            gate_q  <= 1'b0;
            armed_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            gate_q  <= gate_i;
            armed_q <= 1'b1;
            out_q   <= out_d;
        end
    end

    assign out_o       = out_q;
    assign env_level_o = env_level;
    assign active_o    = (state_q != StIdle);

endmodule

// File: tb/tb_adsr_vca.sv
// Directed bench for adsr_vca: reset, attack, decay/sustain, release, retrigger, edge priority.
module tb_adsr_vca;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAttack  = 3'd1;
    localparam logic [2:0] StDecay   = 3'd2;
    localparam logic [2:0] StSustain = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        gate;
    logic [3:0]  attack, decay, sustain, rel;
    logic [11:0] in;
    logic [11:0] out;
    logic [7:0]  env;
    logic        active;

    int checks = 0;
    int errors = 0;

    adsr_vca #(.DATA_BITS(12), .ACC_BITS(24)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .gate_i      (gate),
        .attack_i    (attack),
        .decay_i     (decay),
        .sustain_i   (sustain),
        .release_i   (rel),
        .in_i        (in),
        .out_o       (out),
        .env_level_o (env),
        .active_o    (active)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        checks++; if (out !== 12'd0) begin errors++; $display("FAIL rst_out got %0d exp 0", out); end
        checks++; if (env !== 8'd0) begin errors++; $display("FAIL rst_env got %0d exp 0", env); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %0b exp 0", active); end
        gate = 1'b1;
        tick(1);
        tick(128);
        checks++; if (dut.acc_q !== 24'h400000) begin errors++; $display("FAIL rst_midattack_acc got %0h exp 400000", dut.acc_q); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL rst_midattack_active got %0b exp 1", active); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out !== 12'd0) begin errors++; $display("FAIL rst_async_out got %0d exp 0", out); end
        checks++; if (env !== 8'd0) begin errors++; $display("FAIL rst_async_env got %0d exp 0", env); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_async_active got %0b exp 0", active); end
        tick(1);
        rst = 1'b0;
        tick(5);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_held_gate_active got %0b exp 0", active); end
        checks++; if (env !== 8'd0) begin errors++; $display("FAIL rst_held_gate_env got %0d exp 0", env); end
        gate = 1'b0;
        tick(1);
        gate = 1'b1;
        tick(1);
        checks++; if (dut.state_q !== StAttack) begin errors++; $display("FAIL rst_fresh_rise_state got %0d exp %0d", dut.state_q, StAttack); end
        checks++; if (dut.acc_q !== 24'h0) begin errors++; $display("FAIL rst_fresh_rise_acc got %0h exp 0", dut.acc_q); end
    endtask

    task automatic test_attack;
        in = 12'd2047;
        tick(2);
        checks++; if (env !== 8'd1) begin errors++; $display("FAIL atk_lvl1 got %0d exp 1", env); end
        tick(508);
        checks++; if (env !== 8'd255) begin errors++; $display("FAIL atk_lvl255 got %0d exp 255", env); end
        tick(1);
        checks++; if (out !== 12'd2047) begin errors++; $display("FAIL atk_unity_out got %0d exp 2047", out); end
        checks++; if (dut.state_q !== StAttack) begin errors++; $display("FAIL atk_511_state got %0d exp %0d", dut.state_q, StAttack); end
        in = 12'h800;
        tick(1);
        checks++; if (dut.acc_q !== 24'hFFFFFF) begin errors++; $display("FAIL atk_full_acc got %0h exp ffffff", dut.acc_q); end
        checks++; if (dut.state_q !== StDecay) begin errors++; $display("FAIL atk_full_state got %0d exp %0d", dut.state_q, StDecay); end
        checks++; if (out !== 12'h800) begin errors++; $display("FAIL atk_neg_out got %0h exp 800", out); end
    endtask

    task automatic test_decay_sustain;
        tick(239);
        checks++; if (dut.state_q !== StDecay) begin errors++; $display("FAIL dec_239_state got %0d exp %0d", dut.state_q, StDecay); end
        tick(1);
        checks++; if (dut.state_q !== StSustain) begin errors++; $display("FAIL dec_240_state got %0d exp %0d", dut.state_q, StSustain); end
        checks++; if (env !== 8'd136) begin errors++; $display("FAIL sus_env got %0d exp 136", env); end
        in = 12'd1000;
        tick(1);
        checks++; if (out !== 12'd531) begin errors++; $display("FAIL sus_out got %0d exp 531", out); end
    endtask

    task automatic test_release;
        gate = 1'b0;
        tick(1);
        checks++; if (dut.state_q !== StRelease) begin errors++; $display("FAIL rel_enter_state got %0d exp %0d", dut.state_q, StRelease); end
        checks++; if (dut.acc_q !== 24'h880000) begin errors++; $display("FAIL rel_enter_acc got %0h exp 880000", dut.acc_q); end
        tick(271);
        checks++; if (dut.acc_q !== 24'h008000) begin errors++; $display("FAIL rel_271_acc got %0h exp 8000", dut.acc_q); end
        tick(1);
        checks++; if (dut.state_q !== StIdle) begin errors++; $display("FAIL rel_272_state got %0d exp %0d", dut.state_q, StIdle); end
        checks++; if (dut.acc_q !== 24'h0) begin errors++; $display("FAIL rel_272_acc got %0h exp 0", dut.acc_q); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rel_active got %0b exp 0", active); end
        tick(1);
        checks++; if (out !== 12'd0) begin errors++; $display("FAIL rel_out got %0d exp 0", out); end
    endtask

    task automatic test_retrigger;
        gate = 1'b1;
        tick(1);
        tick(512);
        tick(240);
        checks++; if (dut.state_q !== StSustain) begin errors++; $display("FAIL rtg_sustain_state got %0d exp %0d", dut.state_q, StSustain); end
        gate = 1'b0;
        tick(1);
        tick(144);
        checks++; if (env !== 8'd64) begin errors++; $display("FAIL rtg_env64 got %0d exp 64", env); end
        gate = 1'b1;
        tick(1);
        checks++; if (dut.state_q !== StAttack) begin errors++; $display("FAIL rtg_state got %0d exp %0d", dut.state_q, StAttack); end
        checks++; if (dut.acc_q !== 24'h400000) begin errors++; $display("FAIL rtg_acc got %0h exp 400000", dut.acc_q); end
        tick(383);
        checks++; if (dut.acc_q !== 24'hFF8000) begin errors++; $display("FAIL rtg_383_acc got %0h exp ff8000", dut.acc_q); end
        tick(1);
        checks++; if (dut.acc_q !== 24'hFFFFFF) begin errors++; $display("FAIL rtg_384_acc got %0h exp ffffff", dut.acc_q); end
        checks++; if (dut.state_q !== StDecay) begin errors++; $display("FAIL rtg_384_state got %0d exp %0d", dut.state_q, StDecay); end
    endtask

    task automatic test_back_to_back;
        gate = 1'b0;
        tick(1);
        checks++; if (dut.state_q !== StRelease) begin errors++; $display("FAIL b2b_fall_state got %0d exp %0d", dut.state_q, StRelease); end
        gate = 1'b1;
        tick(1);
        checks++; if (dut.state_q !== StAttack) begin errors++; $display("FAIL b2b_rise_state got %0d exp %0d", dut.state_q, StAttack); end
        checks++; if (dut.acc_q !== 24'hFFFFFF) begin errors++; $display("FAIL b2b_rise_acc got %0h exp ffffff", dut.acc_q); end
        tick(1);
        tick(240);
        checks++; if (env !== 8'd136) begin errors++; $display("FAIL b2b_sus8_env got %0d exp 136", env); end
        sustain = 4'd15;
        tick(1);
        checks++; if (env !== 8'd255) begin errors++; $display("FAIL b2b_sus15_env got %0d exp 255", env); end
        tick(1);
        checks++; if (out !== 12'd1000) begin errors++; $display("FAIL b2b_unity_out got %0d exp 1000", out); end
    endtask

    initial begin
        rst     = 1'b1;
        gate    = 1'b0;
        attack  = 4'd0;
        decay   = 4'd0;
        sustain = 4'd8;
        rel     = 4'd0;
        in      = 12'd2047;
        tick(3);
        rst = 1'b0;
        tick(2);
        test_reset;
        test_attack;
        test_decay_sustain;
        test_release;
        test_retrigger;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
